s_to_p_collect: RTL and testbench
=================================

Name: s_to_p_collect

Overview:
- Downstream companion of the P_TO_S serializer in the BNN datapath.
- Samples the registered single-bit stream the serializer emits and rebuilds the WIDTH-bit parallel word, LSB first.
- Presents the word on a valid/ready output register to the next layer (weight XNOR / accumulate stage).
- Shares the serializer's active-low EN so both stages start on the same edge; the EN sampling rule below absorbs the serializer's leading 0.

Parameters:
- WIDTH, 16: bits per word; must equal the upstream serializer WIDTH; legal range 2..64.
- CW, $clog2(WIDTH+1): bit-counter / ones-count width (derived, not overridden).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous active-high reset.
- EN  input  1  active-low enable; same net as the serializer EN.
- S_IN  input  1  serial data; connected directly to P_TO_S_OUT.
- OUT_READY  input  1  consumer accepts the word on an edge where OUT_VALID=1.
- P_OUT  output  WIDTH  collected word; bit i = i-th data bit received.
- OUT_VALID  output  1  P_OUT holds an unconsumed word.
- BUSY  output  1  high in SKIP or SHIFT.
- OVERRUN  output  1  sticky; a completed word overwrote an unconsumed one.

Behaviour:
- All state is updated on the CLK rising edge. RST is synchronous and overrides everything else.
- Reset values: state=IDLE, cnt=0, shift register=0, P_OUT=0, OUT_VALID=0, BUSY=0, OVERRUN=0.
- FSM states: IDLE, SKIP, SHIFT, DONE.
- IDLE: on an edge with EN=0, go to SKIP and clear cnt.
- SKIP: discard S_IN (this is the serializer's leading 0) and go to SHIFT.
- SHIFT: each edge, shreg[cnt] <= S_IN and cnt <= cnt+1.
  - On the edge that captures bit WIDTH-1, load P_OUT with the full word (that last bit included), set OUT_VALID=1, and go to DONE.
- DONE: hold until EN=1, then go to IDLE. The serializer holds its last bit meanwhile, so re-collection requires EN to toggle high.
- EN=1 in SKIP or SHIFT aborts to IDLE. The partial word is discarded; P_OUT, OUT_VALID and OVERRUN are unchanged.
- Latency: edge k is the first edge with EN=0. Bit 0 is captured at edge k+2. OUT_VALID is first high after edge k+1+WIDTH.
- Handshake: OUT_VALID clears on an edge where OUT_VALID=1 and OUT_READY=1. P_OUT is stable while OUT_VALID=1 unless it is overwritten (see OVERRUN).
- Completion and consumption on the same edge: the old word is consumed, the new word is loaded, OUT_VALID stays 1, and OVERRUN is not set.
- Completion while OUT_VALID=1 and OUT_READY=0: the new word overwrites P_OUT, OUT_VALID stays 1, and OVERRUN is set to 1. OVERRUN is cleared only by RST.
- cnt never exceeds WIDTH-1 in SHIFT, so there is no wrap-around.

Optional Feature:
- Macro: S_TO_P_POPCOUNT_EN.
- When defined:
  - Adds output port ONES_CNT [CW-1:0].
  - An incremental counter adds S_IN on each SHIFT edge and clears on entry to SKIP.
  - ONES_CNT is loaded together with P_OUT (final bit included) and has the same handshake and overwrite rules.
  - ONES_CNT resets to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package bnn_serdes_pkg:
  - State enum (IDLE, SKIP, SHIFT, DONE).
  - Helper function for the count width (clog2 of WIDTH+1).
  - Constant SER_LEAD_BITS=1, the serializer's leading-zero cycle count, used by both serializer and collector benches.
- One natural sub-module, s_to_p_onescnt: the gated incremental ones counter, instantiated only under S_TO_P_POPCOUNT_EN.

Test Plan:
- WIDTH=16, serializer driven with 16'hA5C3, EN low from edge k, OUT_READY=1 → P_OUT=16'hA5C3 and OUT_VALID first high after edge k+17; ONES_CNT=8 when the macro is defined.
- Two words 16'h0001 then 16'h8000 with an EN toggle between them, OUT_READY held 0 → P_OUT=16'h8000, OUT_VALID=1, OVERRUN=1.
- Same two words, with OUT_READY pulsed on the exact completion edge of the second word → P_OUT=16'h8000, OUT_VALID=1, OVERRUN=0.
- EN raised high after 5 captured bits of 16'hFFFF → state IDLE, OUT_VALID and P_OUT unchanged from the prior value (0 after reset).
- RST asserted mid-SHIFT and mid-DONE → all outputs 0 on the next edge; a following full 16'h1234 transfer completes correctly.
- EN held low for 40 cycles after one 16'h5555 transfer → exactly one word produced (single OUT_VALID rise), FSM stays in DONE.

Source files
------------

// File: rtl/bnn_serdes_pkg.sv
// Shared types and constants for the BNN serializer / collector pair.
package bnn_serdes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    SHIFT,
    DONE
  } ser_state_e;

  // Cycles of leading zero the serializer emits before bit 0.
  localparam int unsigned SER_LEAD_BITS = 1;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/s_to_p_onescnt.sv
// Gated incremental ones counter; result register loads alongside the collected word.
module s_to_p_onescnt #(
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc_en,
  input  logic          bit_in,
  input  logic          load,
  output logic [CW-1:0] ones_cnt
);

  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] ones_q, ones_d;

  always_comb begin
    acc_d  = acc_q;
    ones_d = ones_q;
    if (clr) begin
      acc_d = '0;
    end else if (inc_en) begin
      acc_d = acc_q + CW'(bit_in);
    end
    // load coincides with the last increment, so take the updated sum
    if (load) begin
      ones_d = acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      ones_q <= '0;
    end else begin
      acc_q  <= acc_d;
      ones_q <= ones_d;
    end
  end

  assign ones_cnt = ones_q;

endmodule

// File: rtl/s_to_p_collect.sv
// Serial-to-parallel collector for the P_TO_S stream, LSB first, with valid/ready output.
// Optional ONES_CNT output enabled by S_TO_P_POPCOUNT_EN.
module s_to_p_collect
  import bnn_serdes_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned CW    = cnt_width(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             S_IN,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] P_OUT,
  output logic             OUT_VALID,
  output logic             BUSY,
  output logic             OVERRUN
`ifdef S_TO_P_POPCOUNT_EN
  ,
  output logic [CW-1:0]    ONES_CNT
`endif
);

  ser_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] p_out_q, p_out_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    p_out_d     = p_out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!EN) begin
          state_d = SKIP;
          cnt_d   = '0;
        end
      end
      SKIP: begin
        state_d = EN ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (EN) begin
          state_d = IDLE;
        end else begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(i)) shreg_d[i] = S_IN;
          end
          cnt_d = cnt_q + CW'(1);
          // completion overrides the consume above; overrun only if nobody took the old word
          if (cnt_q == CW'(WIDTH - 1)) begin
            p_out_d     = shreg_d;
            out_valid_d = 1'b1;
            if (out_valid_q && !OUT_READY) overrun_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (EN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      p_out_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      p_out_q     <= p_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign P_OUT     = p_out_q;
  assign OUT_VALID = out_valid_q;
  assign OVERRUN   = overrun_q;
  assign BUSY      = (state_q == SKIP) || (state_q == SHIFT);

`ifdef S_TO_P_POPCOUNT_EN
  logic skip_entry, shift_en, word_load;

  assign skip_entry = (state_q == IDLE) && !EN;
  assign shift_en   = (state_q == SHIFT) && !EN;
  assign word_load  = shift_en && (cnt_q == CW'(WIDTH - 1));

  s_to_p_onescnt #(
    .CW(CW)
  ) u_onescnt (
    .clk      (CLK),
    .rst      (RST),
    .clr      (skip_entry),
    .inc_en   (shift_en),
    .bit_in   (S_IN),
    .load     (word_load),
    .ones_cnt (ONES_CNT)
  );
`endif

endmodule

// File: tb/tb_s_to_p_collect.sv
// Self-checking bench for s_to_p_collect: directed scenarios plus random EN/S_IN/OUT_READY traffic.
module tb_s_to_p_collect;
  import bnn_serdes_pkg::*;

  localparam int unsigned W   = 16;
  localparam int unsigned CWB = $clog2(W + 1);
  localparam int unsigned FIRST_CAP = 2 + SER_LEAD_BITS;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b1;
  logic           s_in = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   p_out;
  logic           out_valid;
  logic           busy;
  logic           overrun;
`ifdef S_TO_P_POPCOUNT_EN
  logic [CWB-1:0] ones_cnt;
`endif

  s_to_p_collect #(
    .WIDTH(W)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .EN        (en),
    .S_IN      (s_in),
    .OUT_READY (out_ready),
    .P_OUT     (p_out),
    .OUT_VALID (out_valid),
    .BUSY      (busy),
    .OVERRUN   (overrun)
`ifdef S_TO_P_POPCOUNT_EN
    ,
    .ONES_CNT  (ones_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: 'run' counts consecutive EN-low edges since the last EN-high edge or reset.
  int unsigned run = 0;
  logic [W-1:0] cap = '0;
  logic [W-1:0] m_p = '0;
  logic         m_valid = 1'b0;
  logic         m_over = 1'b0;
  int unsigned  m_ones = 0;

  int unsigned  edge_cnt = 0;
  int unsigned  last_rise_edge = 0;
  int unsigned  valid_rises = 0;
  logic         prev_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic e, input logic sin, input logic rdy);
    logic done;
    done = 1'b0;
    if (r) begin
      run = 0; cap = '0; m_p = '0; m_valid = 1'b0; m_over = 1'b0; m_ones = 0;
    end else begin
      if (e) begin
        run = 0;
      end else begin
        if (run < 100000) run++;
        if (run >= FIRST_CAP && run <= FIRST_CAP + W - 1) cap[run - FIRST_CAP] = sin;
        if (run == FIRST_CAP + W - 1) done = 1'b1;
      end
      if (done) begin
        if (m_valid && !rdy) m_over = 1'b1;
        m_p     = cap;
        m_valid = 1'b1;
        m_ones  = $countones(cap);
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic sin, input logic rdy);
    logic m_busy;
    @(negedge clk);
    rst = r; en = e; s_in = sin; out_ready = rdy;
    @(posedge clk);
    edge_cnt++;
    model_edge(r, e, sin, rdy);
    #1;
    m_busy = (run >= 1) && (run <= FIRST_CAP + W - 2);
    check_eq("p_out", p_out, m_p);
    check_eq("out_valid", out_valid, m_valid);
    check_eq("busy", busy, m_busy);
    check_eq("overrun", overrun, m_over);
`ifdef S_TO_P_POPCOUNT_EN
    check_eq("ones_cnt", ones_cnt, m_ones);
`endif
    if (out_valid && !prev_valid) begin
      valid_rises++;
      last_rise_edge = edge_cnt;
    end
    prev_valid = out_valid;
  endtask

  // mode 0: ready low; 1: ready high; 2: ready only on the completion edge
  task automatic send_word(input logic [W-1:0] w, input int mode);
    logic [W-1:0] wv;
    wv = w;
    step(1'b0, 1'b0, 1'b0, mode == 1);
    for (int unsigned j = 0; j < SER_LEAD_BITS; j++) step(1'b0, 1'b0, 1'b0, mode == 1);
    for (int unsigned i = 0; i < W; i++)
      step(1'b0, 1'b0, wv[i], (mode == 1) || (mode == 2 && i == W - 1));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_p"}, p_out, '0);
    check_eq({tag, "_v"}, out_valid, 1'b0);
    check_eq({tag, "_b"}, busy, 1'b0);
    check_eq({tag, "_o"}, overrun, 1'b0);
  endtask

  initial begin
    int unsigned k_edge;

    // reset state
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_zero("reset");
    step(1'b0, 1'b1, 1'b0, 1'b0);

    // single word, latency
    k_edge = edge_cnt + 1;
    send_word(16'hA5C3, 1);
    check_eq("t1_p", p_out, 16'hA5C3);
    check_eq("t1_v", out_valid, 1'b1);
    check_eq("t1_lat", last_rise_edge, k_edge + 1 + W);
`ifdef S_TO_P_POPCOUNT_EN
    check_eq("t1_ones", ones_cnt, 8);
`endif
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("t1_consumed", out_valid, 1'b0);

    // overwrite without consumption
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    send_word(16'h0001, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    send_word(16'h8000, 0);
    check_eq("t2_p", p_out, 16'h8000);
    check_eq("t2_v", out_valid, 1'b1);
    check_eq("t2_ovr", overrun, 1'b1);

    // consume on the completion edge
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    send_word(16'h0001, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    send_word(16'h8000, 2);
    check_eq("t3_p", p_out, 16'h8000);
    check_eq("t3_v", out_valid, 1'b1);
    check_eq("t3_ovr", overrun, 1'b0);

    // abort after 5 bits
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_zero("t4");

    // reset mid-SHIFT, mid-DONE, then a clean transfer
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_zero("t5a");
    step(1'b0, 1'b1, 1'b0, 1'b0);
    send_word(16'hBEEF, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_zero("t5b");
    step(1'b0, 1'b1, 1'b0, 1'b0);
    send_word(16'h1234, 1);
    check_eq("t5_p", p_out, 16'h1234);
    check_eq("t5_v", out_valid, 1'b1);

    // EN held low: exactly one word
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    valid_rises = 0;
    send_word(16'h5555, 0);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_eq("t6_busy", busy, 1'b0);
    end
    check_eq("t6_rises", valid_rises, 1);
    check_eq("t6_p", p_out, 16'h5555);

    // random traffic
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 299) == 0),
           1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
